clkdiv_monitor: RTL

//  Receive-side checker for a divided clock generated in the same clk domain.

---
 rtl/clkdiv_monitor.sv | 123 ++++++++++++
 1 files changed

// File: rtl/clkdiv_monitor.sv
// Receive-side checker for a divided clock in the clk domain: detects div_in edges,
// measures each half-period, tracks lock and flags bad halves or a stalled input.
module clkdiv_monitor #(
  parameter int CNT_W    = 8,
  parameter int EXP_HALF = 4,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  output logic             edge_rise,
  output logic             edge_fall,
  output logic             meas_valid,
  output logic [CNT_W-1:0] half_period,
  output logic             locked,
  output logic             err_period,
  output logic             err_timeout
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int MW     = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCKED} state_t;

  state_t            state, state_n;
  logic              div_d;
  logic [CNT_W-1:0]  cnt, cnt_n, half_n;
  logic [GOOD_W-1:0] good_cnt, good_n;
  logic              meas_n, errp_n, errt_n;
  logic              edge_s, good_half, timeout_hit;
  logic [MW-1:0]     meas_w, diff_w;

  // Measurement arithmetic is one bit wider than cnt so a saturated count cannot wrap.
  assign edge_s      = en && (div_in != div_d);
  assign meas_w      = MW'(cnt) + MW'(1);
  assign diff_w      = (meas_w >= MW'(EXP_HALF)) ? meas_w - MW'(EXP_HALF)
                                                 : MW'(EXP_HALF) - meas_w;
  assign good_half   = (diff_w <= MW'(TOL));
  assign timeout_hit = !edge_s && (meas_w == MW'(TIMEOUT));

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_n = state;
    cnt_n   = edge_s ? '0 : ((cnt == '1) ? cnt : cnt + CNT_W'(1));
    good_n  = good_cnt;
    half_n  = half_period;
    meas_n  = 1'b0;
    errp_n  = 1'b0;
    errt_n  = 1'b0;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      good_n  = '0;
    end else begin
      unique case (state)
        IDLE: state_n = ACQ;
        ACQ: begin
          if (edge_s) begin
            state_n = TRACK;
            good_n  = '0;
          end else if (timeout_hit) begin
            errt_n = 1'b1;
            cnt_n  = '0;
            good_n = '0;
          end
        end
        TRACK, LOCKED: begin
          if (edge_s) begin
            meas_n = 1'b1;
            half_n = meas_w[CNT_W] ? '1 : meas_w[CNT_W-1:0];
            if (!good_half) begin
              errp_n  = 1'b1;
              good_n  = '0;
              state_n = TRACK;
            end else if (state == TRACK) begin
              good_n = good_cnt + GOOD_W'(1);
              if (int'(good_cnt) + 1 == LOCK_CNT) state_n = LOCKED;
            end
          end else if (timeout_hit) begin
            errt_n  = 1'b1;
            cnt_n   = '0;
            good_n  = '0;
            state_n = ACQ;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div_d       <= 1'b0;
      cnt         <= '0;
      good_cnt    <= '0;
      edge_rise   <= 1'b0;
      edge_fall   <= 1'b0;
      meas_valid  <= 1'b0;
      half_period <= '0;
      locked      <= 1'b0;
      err_period  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state       <= state_n;
      div_d       <= div_in;
      cnt         <= cnt_n;
      good_cnt    <= good_n;
      edge_rise   <= edge_s && div_in;
      edge_fall   <= edge_s && !div_in;
      meas_valid  <= meas_n;
      half_period <= half_n;
      locked      <= (state_n == LOCKED);
      err_period  <= errp_n;
      err_timeout <= errt_n;
    end
  end

endmodule
